// File: rtl/kria_fft_pkg.sv
// kria_fft_pkg: shared stream width, averager state type and accumulator sizing
package kria_fft_pkg;
  localparam int AXIS_DW = 32;
  typedef enum logic [1:0] {FIRST, ACCUM, LAST} avg_state_t;
  function automatic int acc_width(input int log2_avg);
    return AXIS_DW + log2_avg;
  endfunction
endpackage

// File: rtl/avg_acc_ram.sv
// avg_acc_ram: simple dual-port accumulator RAM, synchronous read, BRAM-inferable
//   clk   - clock
//   we    - write enable, waddr/wdata - write port
//   raddr - read address, rdata - registered read data (one cycle later)
module avg_acc_ram
  import kria_fft_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WIDTH = acc_width(4),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/power_spectrum_avg.sv
// power_spectrum_avg: averages 2^LOG2_AVG power frames bin-by-bin and emits one frame
//   aclk/aresetn        - clock, async active-low reset
//   s_axis_*            - input power stream, one bin per beat, tlast on bin NFFT-1
//   m_axis_*            - averaged output stream, tkeep fixed at 4'hF
//   frame_err           - sticky frame-length violation flag
module power_spectrum_avg
  import kria_fft_pkg::*;
#(
  parameter int NFFT = 1024,
  parameter int LOG2_AVG = 4
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [AXIS_DW-1:0] s_axis_tdata,
  input  logic [3:0]         s_axis_tkeep,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  output logic               s_axis_tready,
  output logic [AXIS_DW-1:0] m_axis_tdata,
  output logic [3:0]         m_axis_tkeep,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready,
  output logic               frame_err
);
  localparam int ACCW = acc_width(LOG2_AVG);
  localparam int BW = $clog2(NFFT);
  localparam int FW = LOG2_AVG > 0 ? LOG2_AVG : 1;
  localparam logic [BW-1:0] BIN_MAX = BW'(NFFT - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'((1 << LOG2_AVG) - 1);
  avg_state_t state_q, state_d;
  logic [BW-1:0] bin_q, bin_d;
  logic [FW-1:0] frm_q, frm_d;
  logic err_q, err_d;
  logic rdy_en_q, rdy_en_d;
  logic m_valid_q, m_valid_d;
  logic m_last_q, m_last_d;
  logic [AXIS_DW-1:0] m_data_q, m_data_d;
  logic is_last, fire, bin_end, bad_len, ram_we;
  logic [ACCW-1:0] ram_rdata, acc_base, acc_sum;
  logic unused_tkeep;
  assign unused_tkeep = ^s_axis_tkeep;
  // With a single frame per average every frame is the last one
  assign is_last = state_q == LAST || LOG2_AVG == 0;
  assign fire = s_axis_tvalid && s_axis_tready;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= FIRST;
      bin_q     <= '0;
      frm_q     <= '0;
      err_q     <= 1'b0;
      rdy_en_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      frm_q     <= frm_d;
      err_q     <= err_d;
      rdy_en_q  <= rdy_en_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end
  always_comb begin
    rdy_en_d = 1'b1;
    bin_end = bin_q == BIN_MAX;
    bad_len = fire && (s_axis_tlast != bin_end);
    // A length violation restarts the average from a clean frame
    bin_d = !fire ? bin_q : (bad_len || bin_end) ? '0 : bin_q + 1'b1;
    frm_d = !fire ? frm_q : bad_len ? '0 : !bin_end ? frm_q : (frm_q == FRM_MAX) ? '0 : frm_q + 1'b1;
    state_d = frm_d == FRM_MAX ? LAST : frm_d == '0 ? FIRST : ACCUM;
    err_d = err_q || bad_len;
  end
  always_comb begin
    s_axis_tready = rdy_en_q && (!is_last || !m_valid_q || m_axis_tready);
    acc_base = (state_q == FIRST || LOG2_AVG == 0) ? '0 : ram_rdata;
    acc_sum = acc_base + ACCW'(s_axis_tdata);
    ram_we = fire && !is_last;
    m_valid_d = (fire && is_last) || (m_valid_q && !m_axis_tready);
    m_data_d = (fire && is_last) ? AXIS_DW'(acc_sum >> LOG2_AVG) : m_data_q;
    m_last_d = (fire && is_last) ? (bin_end || bad_len) : m_last_q;
  end
  // Read address tracks the next bin so the stored partial sum is ready when its beat arrives
  avg_acc_ram #(.DEPTH(NFFT), .WIDTH(ACCW)) u_ram (
    .clk  (aclk),
    .we   (ram_we),
    .waddr(bin_q),
    .wdata(acc_sum),
    .raddr(bin_d),
    .rdata(ram_rdata)
  );
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = 4'hF;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign frame_err     = err_q;
endmodule

// File: tb/tb_power_spectrum_avg.sv
// tb_power_spectrum_avg: directed checks of the averager at LOG2_AVG 0, 2 and 8
module tb_power_spectrum_avg;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;
  logic [31:0] s_data = '0;
  logic s_last = 1'b0;
  logic [3:0] s_keep = 4'hA;
  logic [2:0] s_valid = '0;
  logic m_ready = 1'b1;
  logic [2:0] s_ready, m_valid, m_last, f_err;
  logic [31:0] m_data [3];
  logic [3:0] m_keep [3];
  int errors = 0;
  int checks = 0;
  logic bp_en = 1'b0;
  logic in_last = 1'b0;
  int stall_bad = 0, rule_bad = 0, stalls = 0;
  logic hold_v = 1'b0;
  logic [32:0] hold = '0;
  logic [32:0] q0[$], q2[$], q8[$];
  power_spectrum_avg #(.NFFT(8), .LOG2_AVG(0)) u0 (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(s_data), .s_axis_tkeep(s_keep),
    .s_axis_tvalid(s_valid[0]), .s_axis_tlast(s_last), .s_axis_tready(s_ready[0]),
    .m_axis_tdata(m_data[0]), .m_axis_tkeep(m_keep[0]), .m_axis_tvalid(m_valid[0]),
    .m_axis_tlast(m_last[0]), .m_axis_tready(m_ready), .frame_err(f_err[0]));
  power_spectrum_avg #(.NFFT(8), .LOG2_AVG(2)) u2 (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(s_data), .s_axis_tkeep(s_keep),
    .s_axis_tvalid(s_valid[1]), .s_axis_tlast(s_last), .s_axis_tready(s_ready[1]),
    .m_axis_tdata(m_data[1]), .m_axis_tkeep(m_keep[1]), .m_axis_tvalid(m_valid[1]),
    .m_axis_tlast(m_last[1]), .m_axis_tready(m_ready), .frame_err(f_err[1]));
  power_spectrum_avg #(.NFFT(8), .LOG2_AVG(8)) u8 (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(s_data), .s_axis_tkeep(s_keep),
    .s_axis_tvalid(s_valid[2]), .s_axis_tlast(s_last), .s_axis_tready(s_ready[2]),
    .m_axis_tdata(m_data[2]), .m_axis_tkeep(m_keep[2]), .m_axis_tvalid(m_valid[2]),
    .m_axis_tlast(m_last[2]), .m_axis_tready(m_ready), .frame_err(f_err[2]));
  always @(posedge aclk) begin
    #1 m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge aclk) begin
    if (m_valid[0] && m_ready) q0.push_back({m_last[0], m_data[0]});
    if (m_valid[1] && m_ready) q2.push_back({m_last[1], m_data[1]});
    if (m_valid[2] && m_ready) q8.push_back({m_last[2], m_data[2]});
    if (hold_v && (!m_valid[1] || {m_last[1], m_data[1]} != hold)) stall_bad++;
    if (in_last && s_ready[1] != (!m_valid[1] || m_ready)) rule_bad++;
    if (m_valid[1] && !m_ready) stalls++;
    hold_v = m_valid[1] && !m_ready;
    hold = {m_last[1], m_data[1]};
  end
  task automatic sync;
    @(posedge aclk);
    #1;
  endtask
  task automatic send(input int d, input logic [31:0] v, input logic l);
    s_data = v;
    s_last = l;
    s_valid = '0;
    s_valid[d] = 1'b1;
    for (int n = 0; n <= 200; n++) begin
      @(negedge aclk);
      if (s_ready[d]) break;
      if (n == 200) begin
        errors++;
        checks++;
        $display("FAIL send_timeout dut=%0d: s_axis_tready stayed 0, required 1", d);
      end
    end
    @(posedge aclk);
    #1;
    s_valid = '0;
  endtask
  task automatic frame(input int d, input logic [31:0] base, input logic [31:0] step);
    for (int k = 0; k < 8; k++) send(d, base + step * k, k == 7);
  endtask
  task automatic wait_n(input int d, input int n);
    for (int i = 0; i < 200; i++) begin
      if ((d == 0 ? q0.size() : d == 1 ? q2.size() : q8.size()) >= n) break;
      @(negedge aclk);
    end
    sync();
  endtask
  task automatic test_reset;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (s_ready[d] !== 1'b0) begin errors++; $display("FAIL reset_tready dut=%0d: got %b, required 0", d, s_ready[d]); end
      checks++;
      if ({m_valid[d], m_last[d], f_err[d]} !== 3'b000) begin errors++; $display("FAIL reset_flags dut=%0d: got %b, required 000", d, {m_valid[d], m_last[d], f_err[d]}); end
      checks++;
      if (m_data[d] !== 32'd0) begin errors++; $display("FAIL reset_tdata dut=%0d: got %h, required 0", d, m_data[d]); end
      checks++;
      if (m_keep[d] !== 4'hF) begin errors++; $display("FAIL reset_tkeep dut=%0d: got %h, required f", d, m_keep[d]); end
    end
    aresetn = 1'b1;
    #1;
    checks++;
    if (s_ready[1] !== 1'b0) begin errors++; $display("FAIL release_tready_early: got %b, required 0", s_ready[1]); end
    @(negedge aclk);
    checks++;
    if (s_ready[1] !== 1'b1) begin errors++; $display("FAIL release_tready: got %b, required 1", s_ready[1]); end
    sync();
  endtask
  task automatic test_const;
    q2.delete();
    for (int f = 0; f < 3; f++) frame(1, 32'd100, 32'd0);
    checks++;
    if (q2.size() != 0) begin errors++; $display("FAIL const_early_out: got %0d beats, required 0", q2.size()); end
    frame(1, 32'd100, 32'd0);
    wait_n(1, 8);
    checks++;
    if (q2.size() != 8) begin errors++; $display("FAIL const_count: got %0d beats, required 8", q2.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (q2[k] !== {k == 7, 32'd100}) begin errors++; $display("FAIL const_beat%0d: got %h, required %h", k, q2[k], {k == 7, 32'd100}); end
    end
  endtask
  task automatic test_ramp;
    q2.delete();
    for (int f = 0; f < 4; f++) frame(1, 32'(f), 32'd1);
    wait_n(1, 8);
    checks++;
    if (q2.size() != 8) begin errors++; $display("FAIL ramp_count: got %0d beats, required 8", q2.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (q2[k] !== {k == 7, 32'(k + 1)}) begin errors++; $display("FAIL ramp_beat%0d: got %h, required %h", k, q2[k], {k == 7, 32'(k + 1)}); end
    end
  endtask
  task automatic test_passthrough;
    for (int k = 0; k < 8; k++) begin
      send(0, 32'hFFFF_FFFF, k == 7);
      @(negedge aclk);
      checks++;
      if ({m_valid[0], m_last[0], m_data[0]} !== {1'b1, k == 7, 32'hFFFF_FFFF}) begin
        errors++;
        $display("FAIL pass_beat%0d: got v=%b l=%b d=%h, required v=1 l=%b d=ffffffff", k, m_valid[0], m_last[0], m_data[0], k == 7);
      end
      sync();
    end
  endtask
  task automatic test_fullscale;
    q8.delete();
    for (int f = 0; f < 255; f++) frame(2, 32'hFFFF_FFFF, 32'd0);
    checks++;
    if (q8.size() != 0) begin errors++; $display("FAIL full_early_out: got %0d beats, required 0", q8.size()); end
    frame(2, 32'hFFFF_FFFF, 32'd0);
    wait_n(2, 8);
    checks++;
    if (q8.size() != 8) begin errors++; $display("FAIL full_count: got %0d beats, required 8", q8.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (q8[k] !== {k == 7, 32'hFFFF_FFFF}) begin errors++; $display("FAIL full_beat%0d: got %h, required %h", k, q8[k], {k == 7, 32'hFFFF_FFFF}); end
    end
  endtask
  task automatic test_backpressure;
    logic [63:0] s;
    q2.delete();
    stall_bad = 0;
    rule_bad = 0;
    stalls = 0;
    bp_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      in_last = f == 3 || f == 7;
      frame(1, 32'(f * 1000 + 3), 32'(7 + f));
      in_last = 1'b0;
    end
    wait_n(1, 16);
    bp_en = 1'b0;
    sync();
    checks++;
    if (q2.size() != 16) begin errors++; $display("FAIL bp_count: got %0d beats, required 16", q2.size()); end
    for (int a = 0; a < 2; a++) begin
      for (int k = 0; k < 8; k++) begin
        s = '0;
        for (int f = 4 * a; f < 4 * a + 4; f++) s += 64'(f * 1000 + 3 + (7 + f) * k);
        checks++;
        if (q2[8 * a + k] !== {k == 7, 32'(s >> 2)}) begin
          errors++;
          $display("FAIL bp_avg%0d_beat%0d: got %h, required %h", a, k, q2[8 * a + k], {k == 7, 32'(s >> 2)});
        end
      end
    end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stalls, required 0", stall_bad); end
    checks++;
    if (rule_bad != 0) begin errors++; $display("FAIL bp_tready_rule: got %0d violations, required 0", rule_bad); end
    checks++;
    if (stalls == 0) begin errors++; $display("FAIL bp_no_stall: got %0d stalled cycles, required >0", stalls); end
  endtask
  task automatic test_early_tlast;
    q2.delete();
    frame(1, 32'd50, 32'd0);
    for (int k = 0; k < 6; k++) send(1, 32'd50, k == 5);
    checks++;
    if (f_err !== 3'b010) begin errors++; $display("FAIL early_err: got %b, required 010", f_err); end
    for (int f = 0; f < 4; f++) frame(1, 32'(f), 32'd1);
    wait_n(1, 8);
    checks++;
    if (q2.size() != 8) begin errors++; $display("FAIL early_count: got %0d beats, required 8", q2.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (q2[k] !== {k == 7, 32'(k + 1)}) begin errors++; $display("FAIL early_beat%0d: got %h, required %h", k, q2[k], {k == 7, 32'(k + 1)}); end
    end
    checks++;
    if (f_err[1] !== 1'b1) begin errors++; $display("FAIL early_sticky: got %b, required 1", f_err[1]); end
  endtask
  task automatic test_reset_midaccum;
    q2.delete();
    frame(1, 32'd5000, 32'd0);
    frame(1, 32'd5000, 32'd0);
    for (int k = 0; k < 3; k++) send(1, 32'd5000, 1'b0);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    sync();
    checks++;
    if (f_err[1] !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, required 0", f_err[1]); end
    for (int f = 0; f < 4; f++) frame(1, 32'd40, 32'd0);
    wait_n(1, 8);
    checks++;
    if (q2.size() != 8) begin errors++; $display("FAIL rst_count: got %0d beats, required 8", q2.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (q2[k] !== {k == 7, 32'd40}) begin errors++; $display("FAIL rst_beat%0d: got %h, required %h", k, q2[k], {k == 7, 32'd40}); end
    end
  endtask
  initial begin
    test_reset();
    test_const();
    test_ramp();
    test_passthrough();
    test_fullscale();
    test_backpressure();
    test_early_tlast();
    test_reset_midaccum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/power_spectrum_avg.md
# power_spectrum_avg

Streaming spectral averager directly downstream of the power-magnitude stage in the Kria FFT chain. Consumes one 32-bit power value per FFT bin over AXI-Stream, frames delimited by `tlast`. Accumulates 2^LOG2_AVG consecutive frames bin-by-bin in on-chip RAM, then emits one averaged frame to the DMA. Cuts DMA bandwidth by 2^LOG2_AVG and lowers the noise floor.

## Interface
- `NFFT`, 1024 — bins per frame; power of two, 8..8192.
- `LOG2_AVG`, 4 — log2 of frames per average; 0..8. With 0, every input frame is passed through.
- `aclk` in 1 — the single clock.
- `aresetn` in 1 — reset; asynchronous and active-low.
- `s_axis_tdata` in 32 — unsigned power value for the current bin.
- `s_axis_tkeep` in 4 — accepted but ignored.
- `s_axis_tvalid` in 1 — input beat valid.
- `s_axis_tlast` in 1 — last bin of the input frame.
- `s_axis_tready` out 1 — block accepts the input beat.
- `m_axis_tdata` out 32 — averaged power for the current bin.
- `m_axis_tkeep` out 4 — constant 4'hF.
- `m_axis_tvalid` out 1 — output beat valid.
- `m_axis_tlast` out 1 — high on output bin NFFT-1.
- `m_axis_tready` in 1 — the DMA accepts the output beat.
- `frame_err` out 1 — sticky flag for a frame-length violation. Cleared only by reset.

## Operation
- A bin counter `bin` (0..NFFT-1) advances on every accepted input beat and wraps to 0 after NFFT-1.
- A frame counter `frm` (0..2^LOG2_AVG-1) advances when `bin` wraps.
- The state machine is `FIRST`, then `ACCUM`, then `LAST`:
  - `FIRST` (frm==0): RAM[bin] = input. Any stale RAM content is overwritten, not added to.
  - `ACCUM`: RAM[bin] = RAM[bin] + input.
  - `LAST` (frm==2^LOG2_AVG-1): the output beat is (RAM[bin] + input) >> LOG2_AVG, truncated. RAM is not written.
- When LOG2_AVG==0, `FIRST` and `LAST` coincide. The output is the input value, and RAM is unused.
- Accumulator width is 32+LOG2_AVG bits, so the sum never overflows. The shifted result always fits in 32 bits.
- After `LAST` completes at bin NFFT-1, the state returns to `FIRST`.
- Frame-length check:
  - A violation is `s_axis_tlast`=1 at bin≠NFFT-1, or `s_axis_tlast`=0 at bin==NFFT-1.
  - On a violation, set `frame_err` and consume the beat normally. For bin==NFFT-1 in `LAST`, the output beat is still emitted.
  - Then force `bin`=0 and `frm`=0, with state `FIRST` from the next beat. The partial average is discarded.
  - If the violating beat occurs in `LAST` at bin<NFFT-1, the partial output frame is truncated: that beat is emitted with `m_axis_tlast`=1.

## Timing
- Reset values: `s_axis_tready`=0 while `aresetn`=0, and 1 from the first clock after release. All other outputs are 0: `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `frame_err`. `m_axis_tkeep`=4'hF.
- Counters and state reset to bin=0, frm=0, `FIRST`. RAM is not cleared.
- Throughput is one beat per cycle in every state. RAM read-modify-write on back-to-back beats is forwarded: a write to bin k followed by a read of bin k+1 never conflicts, because the frame length is at least 8.
- In `FIRST` and `ACCUM`, `s_axis_tready`=1 and there is no output.
- In `LAST`, the output register stage is a standard pipeline:
  - `s_axis_tready` = !`m_axis_tvalid` || `m_axis_tready`.
  - Latency is 1 cycle from input accept to `m_axis_tvalid`.
  - `m_axis_tdata` and `m_axis_tlast` are stable while `m_axis_tvalid`=1 and `m_axis_tready`=0.
- On the transition from `LAST` to `FIRST`, input is accepted while the final output beat is still pending, provided the register is free or draining.
- Reset mid-frame: the output beat in flight is dropped, and the next frame starts cleanly in `FIRST`.

## Structure
- The shared package `kria_fft_pkg` holds:
  - `AXIS_DW`=32.
  - The state enum `avg_state_t` {FIRST, ACCUM, LAST}.
  - The function computing accumulator width from LOG2_AVG.
- Sub-module `avg_acc_ram`: simple dual-port RAM, NFFT x (32+LOG2_AVG), synchronous read, one write port. It infers BRAM.
- The top level contains the counters, the state machine, the adder, the shift, and the output register.

## Test plan
- NFFT=8, LOG2_AVG=2. Send 4 frames with every bin=100. Expected: 8 output beats of 100, `tlast` on the 8th, and no output during the first 3 frames.
- NFFT=8, LOG2_AVG=2. Send frames with bin k = k, k+1, k+2, k+3. Expected: output bin k = (4k+6)>>2, giving 1,2,3,4,5,6,7,8.
- NFFT=8, LOG2_AVG=0, input 0xFFFFFFFF. Expected: output 0xFFFFFFFF one cycle later with every beat. For LOG2_AVG=8 with 256 frames at full scale, the output is 0xFFFFFFFF with no wrap.
- Apply random `m_axis_tready` backpressure during `LAST`. Expected: no beat lost or duplicated, data held stable while stalled, and `s_axis_tready` follows the pipeline rule.
- Assert `tlast` early at bin 5 in frame 1. Expected: `frame_err`=1, and the next 4 full frames still produce a correct average.
- Assert `aresetn` in mid-`ACCUM`, then send 4 fresh frames. Expected: the average excludes pre-reset data and `frame_err`=0.
